// File: rtl/sb_arb_pkg.sv
// sb_arb_pkg: shared constants and helpers for the switchboard round-robin
// arbiter (sb_rr_arbiter) and its optional output skid buffer.
package sb_arb_pkg;

   localparam int unsigned SB_DEST_W  = 32;
   localparam int unsigned SB_MAX_REQ = 16;

   // Width of a requester index / mux select for n requesters (n >= 2).
   function automatic int unsigned sb_sel_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // First asserted valid searching ptr, ptr+1, .. n-1, 0, .. ptr-1.
   // Returns n when nothing is valid.
   function automatic int unsigned sb_rr_pick(input logic [SB_MAX_REQ-1:0] valid,
                                              input int unsigned           ptr,
                                              input int unsigned           n);
      int unsigned idx;
      int unsigned pick;
      pick = n;
      for (int unsigned k = 0; k < SB_MAX_REQ; k++) begin
         idx = ptr + k;
         if (idx >= n) idx = idx - n;
         if ((k < n) && (pick == n) && valid[idx[3:0]]) pick = idx;
      end
      return pick;
   endfunction

endpackage

// File: rtl/sb_skid_buf.sv
// sb_skid_buf: 2-entry registered skid buffer. Accepts a word whenever it is
// not full, so in_ready never depends on out_ready. Used by sb_rr_arbiter
// only when SB_ARB_PIPE_EN is defined.
module sb_skid_buf #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         push, pop;

   // Occupancy-driven handshake and next-state for the two entries.
   always_comb begin
      in_ready  = (cnt_q != 2'd2);
      out_valid = (cnt_q != 2'd0);
      out_data  = head_q;
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
      head_d    = head_q;
      tail_d    = tail_q;
      cnt_d     = cnt_q;
      case (cnt_q)
         2'd0: if (push) begin
            head_d = in_data;
            cnt_d  = 2'd1;
         end
         2'd1: if (push && pop) begin
            head_d = in_data;
         end else if (push) begin
            tail_d = in_data;
            cnt_d  = 2'd2;
         end else if (pop) begin
            cnt_d  = 2'd0;
         end
         2'd2: if (pop) begin
            head_d = tail_q;
            cnt_d  = 2'd1;
         end
         default: cnt_d = 2'd0;
      endcase
   end

   // Buffer storage and occupancy registers.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/sb_rr_arbiter.sv
// sb_rr_arbiter: packet-aware round-robin merge of N switchboard streams onto
// one port. A grant is held from a packet's first word until its last word is
// accepted. Define SB_ARB_PIPE_EN to register the output through a 2-entry
// skid buffer; otherwise the output is a combinational mux.
module sb_rr_arbiter
   import sb_arb_pkg::*;
#(
   parameter  int unsigned N   = 4,
   parameter  int unsigned DW  = 256,
   localparam int unsigned IDW = sb_sel_w(N)
) (
   input  logic                   clk,
   input  logic                   nreset,
   input  logic [N*DW-1:0]        in_data,
   input  logic [N*SB_DEST_W-1:0] in_dest,
   input  logic [N-1:0]           in_last,
   input  logic [N-1:0]           in_valid,
   output logic [N-1:0]           in_ready,
   output logic [DW-1:0]          out_data,
   output logic [SB_DEST_W-1:0]   out_dest,
   output logic                   out_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [IDW-1:0]         out_src
);

   logic [IDW-1:0]       ptr_q, ptr_d;
   logic [IDW-1:0]       owner_q, owner_d;
   logic                 lock_q, lock_d;

   logic [SB_MAX_REQ-1:0] valid_pad;
   int unsigned           pick;
   logic [IDW-1:0]        gnt;
   logic                  has_gnt, gnt_vld, gnt_last;
   logic [DW-1:0]         gnt_data;
   logic [SB_DEST_W-1:0]  gnt_dest;
   logic                  stage_ready, accept;

   // Select the granted requester: locked owner, else round-robin search.
   always_comb begin
      valid_pad        = '0;
      valid_pad[N-1:0] = in_valid;
      pick             = sb_rr_pick(valid_pad, 32'(ptr_q), N);
      gnt              = '0;
      has_gnt          = 1'b0;
      gnt_vld          = 1'b0;
      if (lock_q) begin
         gnt     = owner_q;
         has_gnt = 1'b1;
         gnt_vld = in_valid[owner_q];
      end else if (pick < N) begin
         gnt     = IDW'(pick);
         has_gnt = 1'b1;
         gnt_vld = 1'b1;
      end
      gnt_data = in_data[gnt*DW +: DW];
      gnt_dest = in_dest[gnt*SB_DEST_W +: SB_DEST_W];
      gnt_last = in_last[gnt];
   end

   // Ready back to the granted requester only; all bits low during reset.
   always_comb begin
      in_ready = '0;
      if (nreset && has_gnt && stage_ready) in_ready[gnt] = 1'b1;
      accept = gnt_vld && stage_ready;
   end

   // Lock on a non-last word, release and advance the pointer on a last word.
   always_comb begin
      ptr_d   = ptr_q;
      lock_d  = lock_q;
      owner_d = owner_q;
      if (accept) begin
         if (gnt_last) begin
            lock_d = 1'b0;
            ptr_d  = (gnt == IDW'(N - 1)) ? '0 : gnt + IDW'(1);
         end else begin
            lock_d  = 1'b1;
            owner_d = gnt;
         end
      end
   end

   // Arbitration state registers.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         ptr_q   <= '0;
         lock_q  <= 1'b0;
         owner_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
         owner_q <= owner_d;
      end
   end

`ifdef SB_ARB_PIPE_EN
   localparam int unsigned BW = DW + SB_DEST_W + 1 + IDW;

   logic          buf_valid;
   logic [BW-1:0] buf_out;

   sb_skid_buf #(.W(BW)) u_skid (
      .clk       (clk),
      .nreset    (nreset),
      .in_valid  (gnt_vld),
      .in_ready  (stage_ready),
      .in_data   ({gnt_data, gnt_dest, gnt_last, gnt}),
      .out_valid (buf_valid),
      .out_ready (out_ready),
      .out_data  (buf_out)
   );

   // Unpack the registered word onto the output port.
   always_comb begin
      {out_data, out_dest, out_last, out_src} = buf_out;
      out_valid = buf_valid;
   end
`else
   // Combinational output mux, forced to zero while reset is asserted.
   always_comb begin
      stage_ready = out_ready;
      out_valid   = nreset && gnt_vld;
      out_data    = nreset ? gnt_data : '0;
      out_dest    = nreset ? gnt_dest : '0;
      out_last    = nreset && gnt_last;
      out_src     = nreset ? gnt : '0;
   end
`endif

endmodule

// File: tb/tb_sb_rr_arbiter.sv
// tb_sb_rr_arbiter: randomized self-checking bench for sb_rr_arbiter in its
// default (combinational) configuration, N=4, DW=32.
module tb_sb_rr_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned DW  = 32;
   localparam int unsigned IDW = 2;

   logic              clk = 1'b0;
   logic              nreset;
   logic [N*DW-1:0]   in_data;
   logic [N*32-1:0]   in_dest;
   logic [N-1:0]      in_last, in_valid, in_ready;
   logic [DW-1:0]     out_data;
   logic [31:0]       out_dest;
   logic              out_last, out_valid, out_ready;
   logic [IDW-1:0]    out_src;

   always #5 clk = ~clk;

   sb_rr_arbiter #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .nreset    (nreset),
      .in_data   (in_data),
      .in_dest   (in_dest),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_dest  (out_dest),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_src   (out_src)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: arbitration rules stated directly.
   int m_ptr, m_lock, m_owner;

   // Per-requester packet generator.
   int          len [N];
   int          pos [N];
   logic [23:0] seq [N];
   logic [31:0] dst [N];
   int          minl = 1, maxl = 4;

   function automatic int model_grant();
      if (m_lock != 0) return m_owner;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_ptr + k) % N;
         if (in_valid[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic new_packet(input int i);
      pos[i] = 0;
      len[i] = $urandom_range(maxl, minl);
      dst[i] = $urandom;
   endtask

   task automatic model_reset();
      m_ptr = 0; m_lock = 0; m_owner = 0;
      for (int i = 0; i < N; i++) new_packet(i);
   endtask

   task automatic drive_inputs(input int vprob, input int rprob, input logic [N-1:0] en);
      for (int i = 0; i < N; i++) begin
         in_valid[i]          = en[i] && ($urandom_range(99) < vprob);
         in_data[i*DW +: DW]  = {8'(i), seq[i]};
         in_dest[i*32 +: 32]  = dst[i];
         in_last[i]           = (pos[i] == len[i] - 1);
      end
      out_ready = ($urandom_range(99) < rprob);
   endtask

   task automatic run_cycle(input int vprob, input int rprob, input logic [N-1:0] en);
      int g;
      logic exp_vld, xfer;
      logic [N-1:0] exp_rdy;
      drive_inputs(vprob, rprob, en);
      @(negedge clk);
      g       = model_grant();
      exp_vld = (g >= 0) && in_valid[g];
      exp_rdy = '0;
      if (g >= 0 && out_ready) exp_rdy[g] = 1'b1;
      check_eq("out_valid", 64'(out_valid), 64'(exp_vld));
      check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (exp_vld) begin
         check_eq("out_src", 64'(out_src), 64'(g));
         check_eq("out_data", 64'(out_data), 64'({8'(g), seq[g]}));
         check_eq("out_dest", 64'(out_dest), 64'(dst[g]));
         check_eq("out_last", 64'(out_last), 64'(pos[g] == len[g] - 1));
      end
      xfer = exp_vld && out_ready;
      @(posedge clk);
      #1;
      if (xfer) begin
         if (pos[g] == len[g] - 1) begin
            m_lock = 0;
            m_ptr  = (g + 1) % N;
            seq[g] = seq[g] + 24'd1;
            new_packet(g);
         end else begin
            m_lock  = 1;
            m_owner = g;
            seq[g]  = seq[g] + 24'd1;
            pos[g]  = pos[g] + 1;
         end
      end
   endtask

   task automatic run_phase(input int cycles, input int vprob, input int rprob,
                            input logic [N-1:0] en, input int lmin, input int lmax);
      minl = lmin;
      maxl = lmax;
      for (int i = 0; i < N; i++) if (pos[i] == 0) new_packet(i);
      for (int c = 0; c < cycles; c++) run_cycle(vprob, rprob, en);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      check_eq({tag, "_in_ready"},  64'(in_ready),  64'(0));
      check_eq({tag, "_out_data"},  64'(out_data),  64'(0));
      check_eq({tag, "_out_dest"},  64'(out_dest),  64'(0));
      check_eq({tag, "_out_last"},  64'(out_last),  64'(0));
      check_eq({tag, "_out_src"},   64'(out_src),   64'(0));
   endtask

   initial begin
      for (int i = 0; i < N; i++) seq[i] = 24'(i * 4096);
      model_reset();
      nreset = 1'b0;
      drive_inputs(100, 100, 4'b1111);
      #1;
      check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      nreset = 1'b1;

      // Requester 1 alone, one 3-word packet; pointer then moves to 2.
      run_phase(3, 100, 100, 4'b0010, 3, 3);
      // All valid, single-word packets: rotation starting at 2.
      run_phase(8, 100, 100, 4'b1111, 1, 1);
      // Long packets from 0 and 2 contending: no interleaving.
      run_phase(12, 100, 100, 4'b0101, 4, 4);
      // Backpressure and owner valid drops.
      run_phase(60, 60, 50, 4'b1111, 1, 4);
      run_phase(40, 50, 100, 4'b1010, 3, 5);

      // Reset in the middle of a packet from requester 2.
      run_phase(2, 100, 100, 4'b0100, 4, 4);
      #2;
      nreset = 1'b0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      @(negedge clk);
      nreset = 1'b1;
      run_phase(6, 100, 100, 4'b0101, 2, 2);

      // Long randomized soak.
      run_phase(2000, 70, 70, 4'b1111, 1, 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
